// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - write-back queue merging ALU and load results into one register-file write port
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   alu_valid/reg/data    ALU result offer; alu_ready accepts it (yields to mem)
//   mem_valid/reg/data    load result offer; mem_ready accepts it (priority source)
//   wb_hold               stalls draining; pushes continue until full
//   write_en/wreg/writedata  register-file write from the queue head (zeros when idle)
//   pend_mask             one bit per register with a queued write outstanding
//   count                 number of queued entries
//
// Build option: define WB_R0_DISCARD_EN to handshake but drop writes to register 0.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [2:0]               alu_reg,
    input  logic [15:0]              alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [2:0]               mem_reg,
    input  logic [15:0]              mem_data,
    output logic                     mem_ready,
    input  logic                     wb_hold,
    output logic                     write_en,
    output logic [2:0]               wreg,
    output logic [15:0]              writedata,
    output logic [7:0]               pend_mask,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [2:0]    reg_q  [DEPTH];
    logic [15:0]   data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic          full;
    logic          take_mem;
    logic          take_alu;
    logic          push;
    logic          pop;
    logic [2:0]    in_reg;
    logic [15:0]   in_data;

    // Readiness depends only on the registered count, so a pop in the same
    // cycle never frees a slot for a push.
    assign full      = (count == CW'(DEPTH));
    assign mem_ready = ~full & ~rst;
    assign alu_ready = ~full & ~mem_valid & ~rst;

    assign take_mem  = mem_valid & mem_ready;
    assign take_alu  = alu_valid & alu_ready;
    assign in_reg    = take_mem ? mem_reg  : alu_reg;
    assign in_data   = take_mem ? mem_data : alu_data;

`ifdef WB_R0_DISCARD_EN
    // Register 0 writes complete the handshake but never occupy a slot.
    assign push = (take_mem | take_alu) & (in_reg != 3'd0);
`else
    assign push = take_mem | take_alu;
`endif

    assign write_en  = (count != '0) & ~wb_hold;
    assign pop       = write_en;
    assign wreg      = write_en ? reg_q[head]  : 3'd0;
    assign writedata = write_en ? data_q[head] : 16'd0;

    // Every live entry, head included, marks its destination as pending.
    always_comb begin
        pend_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count) begin
                pend_mask[reg_q[head + PW'(k)]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                reg_q[tail]  <= in_reg;
                data_q[tail] <= in_data;
                tail         <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - self-checking bench for wb_queue against a queue-based model
module tb_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [2:0]  alu_reg;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [2:0]  mem_reg;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        wb_hold;
    logic        write_en;
    logic [2:0]  wreg;
    logic [15:0] writedata;
    logic [7:0]  pend_mask;
    logic [$clog2(DEPTH):0] count;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_hold(wb_hold), .write_en(write_en), .wreg(wreg), .writedata(writedata),
        .pend_mask(pend_mask), .count(count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    // Model: a plain queue of {reg,data} in acceptance order.
    typedef struct { logic [2:0] r; logic [15:0] d; } ent_t;
    ent_t mq[$];

`ifdef WB_R0_DISCARD_EN
    localparam bit DISCARD = 1'b1;
`else
    localparam bit DISCARD = 1'b0;
`endif

    function automatic logic m_mready();
        return !rst && (mq.size() < DEPTH);
    endfunction

    function automatic logic m_we();
        return (mq.size() != 0) && !wb_hold;
    endfunction

    function automatic logic [7:0] m_pend();
        logic [7:0] m = 8'h00;
        foreach (mq[i]) m[mq[i].r] = 1'b1;
        return m;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            ent_t e;
            logic acc;
            logic we_now;
            we_now = m_we();
            acc = 1'b0;
            if (mem_valid && m_mready()) begin
                e.r = mem_reg; e.d = mem_data; acc = 1'b1;
            end else if (alu_valid && m_mready()) begin
                e.r = alu_reg; e.d = alu_data; acc = 1'b1;
            end
            if (we_now) void'(mq.pop_front());
            if (acc && !(DISCARD && e.r == 3'd0)) mq.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic we_e;
            we_e = m_we();
            chk("m_mem_ready", {31'b0, mem_ready}, {31'b0, m_mready()});
            chk("m_alu_ready", {31'b0, alu_ready}, {31'b0, m_mready() && !mem_valid});
            chk("m_write_en",  {31'b0, write_en},  {31'b0, we_e});
            chk("m_wreg",      {29'b0, wreg},      {29'b0, we_e ? mq[0].r : 3'd0});
            chk("m_writedata", {16'b0, writedata}, {16'b0, we_e ? mq[0].d : 16'd0});
            chk("m_pend_mask", {24'b0, pend_mask}, {24'b0, m_pend()});
            chk("m_count",     32'(count),         32'(mq.size()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; mem_valid = 0;
        alu_reg = 0; alu_data = 0; mem_reg = 0; mem_data = 0;
    endtask

    initial begin
        rst = 1; wb_hold = 0;
        idle();
        tick();
        cmp_en = 1'b1;
        #2;
        chk("rst_count",     32'(count), 0);
        chk("rst_write_en",  {31'b0, write_en}, 0);
        chk("rst_pend",      {24'b0, pend_mask}, 0);
        chk("rst_mem_ready", {31'b0, mem_ready}, 0);
        chk("rst_alu_ready", {31'b0, alu_ready}, 0);
        tick();
        rst = 0;

        // single push into empty queue
        alu_valid = 1; alu_reg = 3'd2; alu_data = 16'h1234;
        #2 chk("s1_alu_ready", {31'b0, alu_ready}, 1);
        tick(); idle();
        #2;
        chk("s1_write_en",  {31'b0, write_en}, 1);
        chk("s1_wreg",      {29'b0, wreg}, 2);
        chk("s1_writedata", {16'b0, writedata}, 32'h1234);
        chk("s1_pend",      {24'b0, pend_mask}, 32'h04);
        tick();
        #2;
        chk("s1_count_after", 32'(count), 0);
        chk("s1_pend_after",  {24'b0, pend_mask}, 0);

        // simultaneous mem and alu offers
        mem_valid = 1; mem_reg = 3'd3; mem_data = 16'h00AA;
        alu_valid = 1; alu_reg = 3'd4; alu_data = 16'h0055;
        #2;
        chk("s2_alu_ready", {31'b0, alu_ready}, 0);
        chk("s2_mem_ready", {31'b0, mem_ready}, 1);
        tick();
        mem_valid = 0;
        #2;
        chk("s2_alu_ready2", {31'b0, alu_ready}, 1);
        chk("s2_wreg_first", {29'b0, wreg}, 3);
        tick(); idle();
        #2;
        chk("s2_wreg_second", {29'b0, wreg}, 4);
        chk("s2_wd_second",   {16'b0, writedata}, 32'h0055);
        tick();

        // fill under hold, then drain
        wb_hold = 1;
        for (int i = 0; i < 5; i++) begin
            mem_valid = 1; mem_reg = 3'(i + 1); mem_data = 16'(16'h0100 + i);
            #2;
            if (i == 4) begin
                chk("s3_count_full", 32'(count), 4);
                chk("s3_mem_ready5", {31'b0, mem_ready}, 0);
            end
            tick();
        end
        idle(); wb_hold = 0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("s3_drain_we",   {31'b0, write_en}, 1);
            chk("s3_drain_wreg", {29'b0, wreg}, 32'(i + 1));
            chk("s3_drain_wd",   {16'b0, writedata}, 32'(16'h0100 + i));
            tick();
        end
        #2 chk("s3_count_empty", 32'(count), 0);

        // duplicate destination
        alu_valid = 1; alu_reg = 3'd5; alu_data = 16'h1111;
        tick();
        alu_data = 16'h2222;
        #2 chk("s4_first_wd", {16'b0, writedata}, 32'h1111);
        tick(); idle();
        #2;
        chk("s4_pend5",     {31'b0, pend_mask[5]}, 1);
        chk("s4_second_wd", {16'b0, writedata}, 32'h2222);
        tick();
        #2 chk("s4_pend_clear", {24'b0, pend_mask}, 0);

        // reset with entries queued; push during reset is ignored
        wb_hold = 1;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_reg = 3'(i + 1); alu_data = 16'(16'hA000 + i);
            tick();
        end
        idle();
        rst = 1; mem_valid = 1; mem_reg = 3'd6; mem_data = 16'hDEAD;
        #2;
        chk("s5_mem_ready_rst", {31'b0, mem_ready}, 0);
        chk("s5_alu_ready_rst", {31'b0, alu_ready}, 0);
        tick();
        rst = 0; wb_hold = 0; idle();
        #2;
        chk("s5_count",    32'(count), 0);
        chk("s5_write_en", {31'b0, write_en}, 0);
        chk("s5_pend",     {24'b0, pend_mask}, 0);
        tick(); tick();

        // register 0 push
        alu_valid = 1; alu_reg = 3'd0; alu_data = 16'hBEEF;
        tick(); idle();
        #2;
`ifdef WB_R0_DISCARD_EN
        chk("s6_write_en", {31'b0, write_en}, 0);
        chk("s6_count",    32'(count), 0);
`else
        chk("s6_write_en", {31'b0, write_en}, 1);
        chk("s6_wreg",     {29'b0, wreg}, 0);
        chk("s6_wd",       {16'b0, writedata}, 32'hBEEF);
`endif
        tick();

        // mixed traffic, model-checked every cycle
        for (int i = 0; i < 32; i++) begin
            mem_valid = (i % 3 == 0);
            alu_valid = (i % 2 == 0);
            wb_hold   = ((i % 7) < 3);
            mem_reg   = 3'(i);
            mem_data  = 16'(i * 16'h0111);
            alu_reg   = 3'(i + 3);
            alu_data  = 16'(16'hF000 + i);
            tick();
        end
        idle(); wb_hold = 0;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        #2 chk("end_count", 32'(count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port alu_valid  input  1  ALU result available.
REQ-005 SHALL have port alu_reg  input  3  ALU destination register.
REQ-006 SHALL have port alu_data  input  16  ALU result.
REQ-007 SHALL have port alu_ready  output  1  ALU result accepted this cycle when high with alu_valid.
REQ-008 SHALL have port mem_valid  input  1  load result available.
REQ-009 SHALL have port mem_reg  input  3  load destination register.
REQ-010 SHALL have port mem_data  input  16  load data.
REQ-011 SHALL have port mem_ready  output  1  load accepted this cycle when high with mem_valid.
REQ-012 SHALL have port wb_hold  input  1  suspends draining to the register file.
REQ-013 SHALL have port write_en  output  1  register-file write strobe.
REQ-014 SHALL have port wreg  output  3  register-file write address.
REQ-015 SHALL have port writedata  output  16  register-file write data.
REQ-016 SHALL have port pend_mask  output  8  bit r high when any queued entry targets register r.
REQ-017 SHALL have port count  output  clog2(DEPTH)+1  number of queued entries.

Function
REQ-018 SHALL hold a FIFO of DEPTH entries {reg[2:0], data[15:0]} with wrapping head/tail pointers.
REQ-019 SHALL accept at most one push per cycle; mem has priority over alu.
REQ-020 SHALL drive mem_ready = (count < DEPTH), computed from the registered count only.
REQ-021 SHALL drive alu_ready = (count < DEPTH) & ~mem_valid.
REQ-022 SHALL not admit a push when count == DEPTH, even if a pop occurs in the same cycle.
REQ-023 SHALL drive write_en = (count != 0) & ~wb_hold, with wreg/writedata taken from the head entry.
REQ-024 SHALL pop the head at the rising edge whenever write_en is high.
REQ-025 SHALL have no same-cycle bypass: an entry pushed at edge N asserts write_en no earlier than the cycle after edge N.
REQ-026 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-027 SHALL drive wreg and writedata to 0 while write_en is low.
REQ-028 SHALL derive pend_mask combinationally from all valid entries, including the head being written this cycle.
REQ-029 SHALL, while wb_hold is high, retain all entries and keep accepting pushes until full.
REQ-030 SHALL drain entries in acceptance order, including duplicate destinations, so the last value written wins.

Reset
REQ-031 SHALL, when rst is high at a rising edge, clear count, both pointers, write_en, pend_mask, wreg and writedata to 0.
REQ-032 SHALL discard in-flight entries on reset mid-operation, with no write_en in the cycle after the reset edge.
REQ-033 SHALL ignore any push presented during a reset cycle, and hold alu_ready/mem_ready at 0 while rst is high.

Configuration
REQ-034 SHALL, with WB_R0_DISCARD_EN defined, handshake pushes targeting register 0 normally but not enqueue them; pend_mask[0] is then constant 0 and write_en is never asserted with wreg == 0.
REQ-035 SHALL, without WB_R0_DISCARD_EN, enqueue register-0 pushes like any other register.

Verification
REQ-036 SHALL cover this scenario: single push alu_reg=2, alu_data=0x1234 into an empty queue -> next cycle write_en=1, wreg=2, writedata=0x1234, pend_mask=0x04; the cycle after, count=0 and pend_mask=0.
REQ-037 SHALL cover this scenario: same-cycle mem_valid(reg3, 0x00AA) and alu_valid(reg4, 0x0055) -> mem accepted and alu_ready=0; alu accepted next cycle; writes occur in order reg3 then reg4.
REQ-038 SHALL cover this scenario: wb_hold=1 with 5 pushes at DEPTH=4 -> count=4, mem_ready=0 on the 5th; release hold -> 4 consecutive write_en cycles in FIFO order.
REQ-039 SHALL cover this scenario: two pushes to reg5 with 0x1111 then 0x2222 -> pend_mask[5] stays high until the second write; final writedata to reg5 is 0x2222.
REQ-040 SHALL cover this scenario: rst pulsed with 3 entries queued -> count=0, write_en=0 and pend_mask=0 in the following cycle, and no stale write afterwards.
REQ-041 SHALL cover this scenario: push to reg0 with 0xBEEF -> with WB_R0_DISCARD_EN, no write_en and count stays 0; without it, write_en with wreg=0 and writedata=0xBEEF.
